qp_div6_ctrl: RTL and testbench

- Sequences the per-macroblock split of the luma QP (QPy) and chroma QP (QPc) into quotient and remainder by 6 (QP/6, QP%6), which the inverse-quantisation stage needs for its scaling and shift.
- Sits between QP decoding, which supplies settled QPy/QPc, and the inverse-quant block, which consumes the results through a valid/ready handshake.
- One iterative subtract-by-6 unit is shared between the luma and chroma requests and is time-multiplexed by a small FSM.

---
 rtl/qp_pkg.sv | 12 +
 rtl/qp_div6_step.sv | 31 +++
 rtl/qp_div6_ctrl.sv | 86 ++++++++
 tb/tb_qp_div6_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/qp_pkg.sv
// qp_pkg: shared state encoding, widths and defaults for the QP divide-by-6 controller.
package qp_pkg;
  localparam int QP_W  = 6;
  localparam int DIV_W = 4;
  localparam int MOD_W = 3;
  localparam logic [QP_W-1:0] QP_MAX_DEF   = 6'd51;
  localparam logic [QP_W-1:0] DIV_STEP_DEF = 6'd6;
  typedef enum logic [1:0] {IDLE, LUMA, CHROMA, VALID} qp_state_e;
  function automatic logic [QP_W-1:0] qp_sat(input logic [QP_W-1:0] qp, input logic [QP_W-1:0] qmax);
    return (qp > qmax) ? qmax : qp;
  endfunction
endpackage

// File: rtl/qp_div6_step.sv
// qp_div6_step: shared iterative subtract-by-step unit with remainder/quotient registers.
module qp_div6_step
  import qp_pkg::*;
#(
  parameter logic [QP_W-1:0] DIV_STEP = DIV_STEP_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [QP_W-1:0]  load_val,
  input  logic             step,
  output logic [DIV_W-1:0] quo,
  output logic [MOD_W-1:0] mod,
  output logic             done
);
  logic [QP_W-1:0] rem;
  assign done = rem < DIV_STEP;
  assign mod  = rem[MOD_W-1:0];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem <= '0;
      quo <= '0;
    end else if (load) begin
      rem <= load_val;
      quo <= '0;
    end else if (step && !done) begin
      rem <= rem - DIV_STEP;
      quo <= quo + DIV_W'(1);
    end
  end
endmodule

// File: rtl/qp_div6_ctrl.sv
// qp_div6_ctrl: sequences luma then chroma QP split into QP/6 and QP%6 over one shared step unit.
module qp_div6_ctrl
  import qp_pkg::*;
#(
  parameter logic [QP_W-1:0] QP_MAX   = QP_MAX_DEF,
  parameter logic [QP_W-1:0] DIV_STEP = DIV_STEP_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             qp_start,
  input  logic [QP_W-1:0]  QPy,
  input  logic [QP_W-1:0]  QPc,
  input  logic             iq_ready,
  output logic             qp_busy,
  output logic             qp_valid,
  output logic [DIV_W-1:0] QPy_div6,
  output logic [MOD_W-1:0] QPy_mod6,
  output logic [DIV_W-1:0] QPc_div6,
  output logic [MOD_W-1:0] QPc_mod6,
  output logic             qp_overrun,
  output logic             qp_range_err
);
  qp_state_e state, nxt;
  logic [QP_W-1:0] qpc_cap, load_val;
  logic [DIV_W-1:0] quo;
  logic [MOD_W-1:0] mod;
  logic accept, load, step, done;
  assign accept   = qp_start && (state == IDLE || (state == VALID && iq_ready));
  assign qp_busy  = state != IDLE;
  assign qp_valid = state == VALID;
  always_comb begin
    nxt      = state;
    load     = accept;
    load_val = qp_sat(QPy, QP_MAX);
    step     = 1'b0;
    case (state)
      IDLE:   nxt = accept ? LUMA : IDLE;
      LUMA: begin
        step = 1'b1;
        if (done) begin
          nxt      = CHROMA;
          load     = 1'b1;
          load_val = qpc_cap;
        end
      end
      CHROMA: begin
        step = 1'b1;
        nxt  = done ? VALID : CHROMA;
      end
      VALID:  nxt = !iq_ready ? VALID : (qp_start ? LUMA : IDLE);
      default: nxt = IDLE;
    endcase
  end
  qp_div6_step #(.DIV_STEP(DIV_STEP)) u_step (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
    .step(step), .quo(quo), .mod(mod), .done(done)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      qpc_cap      <= '0;
      QPy_div6     <= '0;
      QPy_mod6     <= '0;
      QPc_div6     <= '0;
      QPc_mod6     <= '0;
      qp_overrun   <= 1'b0;
      qp_range_err <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        qpc_cap <= qp_sat(QPc, QP_MAX);
        if (QPy > QP_MAX || QPc > QP_MAX) qp_range_err <= 1'b1;
      end
      if (qp_start && !accept) qp_overrun <= 1'b1;
      // results only move at the end of a pass; consumers qualify with qp_valid
      if (state == LUMA && done) begin
        QPy_div6 <= quo;
        QPy_mod6 <= mod;
      end
      if (state == CHROMA && done) begin
        QPc_div6 <= quo;
        QPc_mod6 <= mod;
      end
    end
  end
endmodule

// File: tb/tb_qp_div6_ctrl.sv
// tb_qp_div6_ctrl: randomized and directed checks of qp_div6_ctrl against an arithmetic reference.
module tb_qp_div6_ctrl;
  logic clk = 0, reset_n = 0, qp_start = 0, iq_ready = 1;
  logic [5:0] QPy = 0, QPc = 0;
  logic qp_busy, qp_valid, qp_overrun, qp_range_err;
  logic [3:0] QPy_div6, QPc_div6;
  logic [2:0] QPy_mod6, QPc_mod6;
  int vectors = 0, miscompares = 0;
  bit exp_range = 0, exp_ovr = 0;

  qp_div6_ctrl dut (
    .clk(clk), .reset_n(reset_n), .qp_start(qp_start), .QPy(QPy), .QPc(QPc),
    .iq_ready(iq_ready), .qp_busy(qp_busy), .qp_valid(qp_valid),
    .QPy_div6(QPy_div6), .QPy_mod6(QPy_mod6), .QPc_div6(QPc_div6), .QPc_mod6(QPc_mod6),
    .qp_overrun(qp_overrun), .qp_range_err(qp_range_err)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ref_out(input int y, input int c);
    int ys = (y > 51) ? 51 : y;
    int cs = (c > 51) ? 51 : c;
    return {4'(ys / 6), 3'(ys % 6), 4'(cs / 6), 3'(cs % 6)};
  endfunction

  function automatic int ref_lat(input int y, input int c);
    int ys = (y > 51) ? 51 : y;
    int cs = (c > 51) ? 51 : c;
    return ys / 6 + cs / 6 + 2;
  endfunction

  task automatic do_start(input logic [5:0] y, input logic [5:0] c);
    @(negedge clk);
    qp_start = 1; QPy = y; QPc = c;
    @(negedge clk);
    qp_start = 0;
    if (y > 51 || c > 51) exp_range = 1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!qp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_one_mb(input logic [5:0] y, input logic [5:0] c, input int hold, input string name);
    int n;
    logic [13:0] exp_o = ref_out(y, c);
    int lat = ref_lat(y, c);
    if (hold > 0) iq_ready = 0;
    do_start(y, c);
    wait_valid(n);
    vectors++;
    if (n !== lat) begin
      miscompares++;
      $display("FAIL %s latency got %0d want %0d", name, n, lat);
    end
    vectors++;
    if ({QPy_div6, QPy_mod6, QPc_div6, QPc_mod6} !== exp_o) begin
      miscompares++;
      $display("FAIL %s results got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", name,
               QPy_div6, QPy_mod6, QPc_div6, QPc_mod6, exp_o[13:10], exp_o[9:7], exp_o[6:3], exp_o[2:0]);
    end
    vectors++;
    if (qp_range_err !== exp_range || qp_overrun !== exp_ovr) begin
      miscompares++;
      $display("FAIL %s flags got rng=%b ovr=%b want rng=%b ovr=%b", name, qp_range_err, qp_overrun, exp_range, exp_ovr);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if (qp_valid !== 1 || {QPy_div6, QPy_mod6, QPc_div6, QPc_mod6} !== exp_o) begin
        miscompares++;
        $display("FAIL %s hold%0d valid=%b out=%h want valid=1 out=%h", name, i, qp_valid,
                 {QPy_div6, QPy_mod6, QPc_div6, QPc_mod6}, exp_o);
      end
    end
    iq_ready = 1;
    @(negedge clk);
    vectors++;
    if (qp_valid !== 0 || qp_busy !== 0) begin
      miscompares++;
      $display("FAIL %s after_handshake valid=%b busy=%b want 0/0", name, qp_valid, qp_busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({qp_busy, qp_valid, QPy_div6, QPy_mod6, QPc_div6, QPc_mod6, qp_overrun, qp_range_err} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs got busy=%b valid=%b out=%h ovr=%b rng=%b want all 0", qp_busy, qp_valid,
               {QPy_div6, QPy_mod6, QPc_div6, QPc_mod6}, qp_overrun, qp_range_err);
    end
    reset_n = 1;
    exp_range = 0; exp_ovr = 0;
  endtask

  task automatic test_directed;
    test_one_mb(28, 29, 0, "mb_28_29");
    test_one_mb(0, 0, 0, "mb_0_0");
    test_one_mb(51, 39, 0, "mb_51_39");
    test_one_mb(60, 12, 0, "mb_60_12_sat");
    test_one_mb(10, 20, 0, "range_sticky");
  endtask

  task automatic test_back_to_back;
    int n;
    logic [13:0] exp_o = ref_out(40, 17);
    iq_ready = 0;
    do_start(40, 17);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (qp_valid !== 1 || {QPy_div6, QPy_mod6, QPc_div6, QPc_mod6} !== exp_o) begin
        miscompares++;
        $display("FAIL b2b_hold%0d valid=%b out=%h want valid=1 out=%h", i, qp_valid,
                 {QPy_div6, QPy_mod6, QPc_div6, QPc_mod6}, exp_o);
      end
    end
    iq_ready = 1; qp_start = 1; QPy = 6; QPc = 5;
    @(negedge clk);
    qp_start = 0;
    vectors++;
    if (qp_busy !== 1 || qp_valid !== 0) begin
      miscompares++;
      $display("FAIL b2b_restart busy=%b valid=%b want 1/0", qp_busy, qp_valid);
    end
    wait_valid(n);
    vectors++;
    if (n !== ref_lat(6, 5)) begin
      miscompares++;
      $display("FAIL b2b_latency got %0d want %0d", n, ref_lat(6, 5));
    end
    vectors++;
    if ({QPy_div6, QPy_mod6, QPc_div6, QPc_mod6} !== ref_out(6, 5)) begin
      miscompares++;
      $display("FAIL b2b_results got %h want %h", {QPy_div6, QPy_mod6, QPc_div6, QPc_mod6}, ref_out(6, 5));
    end
    @(negedge clk);
    vectors++;
    if (qp_valid !== 0) begin
      miscompares++;
      $display("FAIL b2b_pulse valid=%b want 0", qp_valid);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic [5:0] y = 6'($urandom_range(0, 63));
      logic [5:0] c = 6'($urandom_range(0, 63));
      int hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      test_one_mb(y, c, hold, $sformatf("rand%0d_%0d_%0d", k, y, c));
    end
  endtask

  task automatic test_overrun;
    int n;
    do_start(45, 50);
    repeat (10) @(negedge clk);
    vectors++;
    if (qp_overrun !== 0 || qp_busy !== 1) begin
      miscompares++;
      $display("FAIL ovr_pre overrun=%b busy=%b want 0/1", qp_overrun, qp_busy);
    end
    qp_start = 1; QPy = 0; QPc = 0;
    @(negedge clk);
    qp_start = 0;
    exp_ovr = 1;
    vectors++;
    if (qp_overrun !== 1) begin
      miscompares++;
      $display("FAIL ovr_flag overrun=%b want 1", qp_overrun);
    end
    wait_valid(n);
    vectors++;
    if (n !== ref_lat(45, 50) - 11) begin
      miscompares++;
      $display("FAIL ovr_latency got %0d want %0d", n, ref_lat(45, 50) - 11);
    end
    vectors++;
    if ({QPy_div6, QPy_mod6, QPc_div6, QPc_mod6} !== ref_out(45, 50)) begin
      miscompares++;
      $display("FAIL ovr_results got %h want %h", {QPy_div6, QPy_mod6, QPc_div6, QPc_mod6}, ref_out(45, 50));
    end
    @(negedge clk);
    test_one_mb(13, 7, 0, "ovr_sticky");
  endtask

  task automatic test_reset_mid;
    do_start(51, 51);
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    exp_range = 0; exp_ovr = 0;
    vectors++;
    if ({qp_busy, qp_valid, QPy_div6, QPy_mod6, QPc_div6, QPc_mod6, qp_overrun, qp_range_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got busy=%b valid=%b out=%h ovr=%b rng=%b want all 0", qp_busy, qp_valid,
               {QPy_div6, QPy_mod6, QPc_div6, QPc_mod6}, qp_overrun, qp_range_err);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (qp_valid !== 0 || qp_busy !== 0) begin
        miscompares++;
        $display("FAIL reset_mid_idle%0d valid=%b busy=%b want 0/0", i, qp_valid, qp_busy);
      end
    end
    test_one_mb(33, 22, 0, "post_reset");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_random;
    test_overrun;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
